// File: rtl/excp_ctrl_if.sv
// Signal bundle between excp_ctrl and the pipeline/CP0 side.
// master = pipeline/CP0 side, slave = excp_ctrl.
interface excp_ctrl_if;
  logic [5:0]  int_i;
  logic [5:0]  int_o;
  logic [31:0] excepttype_i;
  logic [31:0] inst_addr_i;
  logic        in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_addr_i;
  logic [31:0] wb_cp0_data_i;
  logic        exc_we_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o;
  logic        exc_bd_o;
  logic        eret_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic [1:0]  dbg_state;

  // Handshake: there is no ready. exc_we_o, eret_o and flush_o are
  // one-cycle pulses that the consumer must take in the cycle they are high.
  // exc_code_o/exc_epc_o/exc_bd_o are only meaningful with exc_we_o.
  // new_pc_o is only meaningful with flush_o. All other cycles they read 0.
  modport master (
    output int_i, excepttype_i, inst_addr_i, in_delayslot_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_addr_i, wb_cp0_data_i,
    input  int_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o,
           eret_o, flush_o, new_pc_o, busy_o, dbg_state
  );

  modport slave (
    input  int_i, excepttype_i, inst_addr_i, in_delayslot_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_addr_i, wb_cp0_data_i,
    output int_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o,
           eret_o, flush_o, new_pc_o, busy_o, dbg_state
  );
endinterface

// File: rtl/excp_ctrl.sv
// MEM-stage exception/interrupt arbiter: picks one exception, feeds CP0 capture data, issues flush.
// Optional macro EXCP_INT_SYNC_EN: adds a 2-flop synchronizer on int_i -> int_o.
module excp_ctrl #(
  parameter int unsigned BLANK_CYCLES = 2,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020
) (
  input logic       clk,
  input logic       rst,
  excp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int CNT_W = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [4:0] EXC_TR  = 5'd13;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] status_byp, cause_byp, epc_byp;
  logic        valid, int_pending, exc_any, take_exc, take_eret;
  logic [4:0]  code_d;
  logic [31:0] epc_d;

  logic        exc_we_q, exc_bd_q, eret_q, flush_q;
  logic [4:0]  exc_code_q;
  logic [31:0] exc_epc_q, new_pc_q;

  // A WB-stage CP0 write has not reached the register file yet; forward it.
  always_comb begin
    status_byp = bus.cp0_status_i;
    cause_byp  = bus.cp0_cause_i;
    epc_byp    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      unique case (bus.wb_cp0_addr_i)
        CP0_STATUS: status_byp = bus.wb_cp0_data_i;
        CP0_CAUSE: begin
          cause_byp[9:8]   = bus.wb_cp0_data_i[9:8];
          cause_byp[23:22] = bus.wb_cp0_data_i[23:22];
        end
        CP0_EPC:    epc_byp = bus.wb_cp0_data_i;
        default:    ;
      endcase
    end
  end

  always_comb begin
    valid       = (bus.inst_addr_i != 32'd0) && (state_q == IDLE);
    int_pending = ((cause_byp[15:8] & status_byp[15:8]) != 8'd0)
                  && status_byp[0] && !status_byp[1];
    exc_any     = 1'b1;
    code_d      = EXC_INT;
    if (int_pending)                code_d = EXC_INT;
    else if (bus.excepttype_i[8])   code_d = EXC_SYS;
    else if (bus.excepttype_i[9])   code_d = EXC_RI;
    else if (bus.excepttype_i[10])  code_d = EXC_TR;
    else if (bus.excepttype_i[11])  code_d = EXC_OV;
    else                            exc_any = 1'b0;
    take_exc  = valid && exc_any;
    take_eret = valid && !exc_any && bus.excepttype_i[12];
    // Wraps mod 2^32, so a delay-slot PC of 4 captures EPC 0.
    epc_d = bus.in_delayslot_i ? (bus.inst_addr_i - 32'd4) : bus.inst_addr_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take_exc || take_eret) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = BLANK;
        cnt_d   = CNT_LOAD;
      end
      BLANK: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are cleared whenever nothing is taken, so every pulse lasts one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_we_q   <= 1'b0;
      exc_code_q <= 5'd0;
      exc_epc_q  <= 32'd0;
      exc_bd_q   <= 1'b0;
      eret_q     <= 1'b0;
      flush_q    <= 1'b0;
      new_pc_q   <= 32'd0;
    end else begin
      exc_we_q   <= take_exc;
      exc_code_q <= take_exc ? code_d : 5'd0;
      exc_epc_q  <= take_exc ? epc_d : 32'd0;
      exc_bd_q   <= take_exc && bus.in_delayslot_i;
      eret_q     <= take_eret;
      flush_q    <= take_exc || take_eret;
      new_pc_q   <= take_exc  ? HANDLER_ADDR :
                    take_eret ? epc_byp      : 32'd0;
    end
  end

  assign bus.exc_we_o   = exc_we_q;
  assign bus.exc_code_o = exc_code_q;
  assign bus.exc_epc_o  = exc_epc_q;
  assign bus.exc_bd_o   = exc_bd_q;
  assign bus.eret_o     = eret_q;
  assign bus.flush_o    = flush_q;
  assign bus.new_pc_o   = new_pc_q;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.dbg_state  = state_q;

`ifdef EXCP_INT_SYNC_EN
  logic [5:0] int_meta_q, int_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_meta_q <= 6'd0;
      int_sync_q <= 6'd0;
    end else begin
      int_meta_q <= bus.int_i;
      int_sync_q <= int_meta_q;
    end
  end

  assign bus.int_o = int_sync_q;
`else
  assign bus.int_o = bus.int_i;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.excepttype_i[31:13], bus.excepttype_i[7:0],
                         status_byp[31:16], status_byp[7:2],
                         cause_byp[31:16], cause_byp[7:0]};

endmodule

// File: tb/tb_excp_ctrl.sv
// Scoreboard bench for excp_ctrl: directed scenarios plus random traffic against a behavioural model.
// Honours EXCP_INT_SYNC_EN for the expected int_o latency.
`timescale 1ns/1ps
module tb_excp_ctrl;
  localparam int BLANK = 2;
  localparam int W     = 80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  excp_ctrl_if bus();

  excp_ctrl #(.BLANK_CYCLES(BLANK), .HANDLER_ADDR(32'h0000_0020)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Vector layout: {exc_we, code[5], epc[32], bd, eret, flush, new_pc[32], busy, int_o[6]}
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: cycles the block still stays busy, and last cycle's int_i.
  int         busy_left = 0;
  logic [5:0] int_prev  = 6'd0;

  int prio_bit [4] = '{8, 9, 10, 11};
  int prio_code[4] = '{8, 10, 13, 12};

  function automatic logic [W-1:0] actual_vec();
    return {bus.exc_we_o, bus.exc_code_o, bus.exc_epc_o, bus.exc_bd_o, bus.eret_o,
            bus.flush_o, bus.new_pc_o, bus.busy_o, bus.int_o};
  endfunction

  task automatic model_push(input logic r, input logic [5:0] ii, input logic [31:0] et,
                            input logic [31:0] pc, input logic ds, input logic [31:0] st,
                            input logic [31:0] ca, input logic [31:0] ep, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] s, c, e, epc_v, npc;
    logic [5:0]  io;
    logic        irq, take, is_eret;
    int          code;
`ifdef EXCP_INT_SYNC_EN
    io       = r ? int_prev : 6'd0;
    int_prev = r ? ii : 6'd0;
`else
    io = ii;
`endif
    if (!r) begin
      busy_left = 0;
      exp_q.push_back({74'd0, io});
      return;
    end
    s = (we && wa == 5'd12) ? wd : st;
    c = ca;
    if (we && wa == 5'd13) begin
      c[9:8]   = wd[9:8];
      c[23:22] = wd[23:22];
    end
    e = (we && wa == 5'd14) ? wd : ep;
    code    = -1;
    is_eret = 1'b0;
    if (busy_left == 0 && pc != 32'd0) begin
      irq = ((c[15:8] & s[15:8]) != 8'd0) && s[0] && !s[1];
      if (irq) code = 0;
      else begin
        for (int k = 0; k < 4; k++)
          if (code < 0 && et[prio_bit[k]]) code = prio_code[k];
        if (code < 0 && et[12]) is_eret = 1'b1;
      end
    end
    take = (code >= 0);
    if (take || is_eret) busy_left = 1 + BLANK;
    else if (busy_left > 0) busy_left = busy_left - 1;
    epc_v = take ? (ds ? pc - 32'd4 : pc) : 32'd0;
    npc   = take ? 32'h20 : (is_eret ? e : 32'd0);
    exp_q.push_back({take, take ? 5'(code) : 5'd0, epc_v, take && ds, is_eret,
                     take || is_eret, npc, busy_left != 0, io});
  endtask

  task automatic drive(input logic r, input logic [5:0] ii, input logic [31:0] et,
                       input logic [31:0] pc, input logic ds, input logic [31:0] st,
                       input logic [31:0] ca, input logic [31:0] ep, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    rst                = r;
    bus.int_i          = ii;
    bus.excepttype_i   = et;
    bus.inst_addr_i    = pc;
    bus.in_delayslot_i = ds;
    bus.cp0_status_i   = st;
    bus.cp0_cause_i    = ca;
    bus.cp0_epc_i      = ep;
    bus.wb_cp0_we_i    = we;
    bus.wb_cp0_addr_i  = wa;
    bus.wb_cp0_data_i  = wd;
    model_push(r, ii, et, pc, ds, st, ca, ep, we, wa, wd);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 6'($urandom), 32'd0, 32'h1000 + 32'(i * 4), 1'b0, 32'd0, 32'd0,
            32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic rand_cycle();
    logic [31:0] et, pc, st, wd;
    logic [4:0]  wa;
    logic        r;
    r  = ($urandom_range(0, 99) != 0);
    et = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom & 32'h0000_1F00);
    if ($urandom_range(0, 3) == 0) et = et | ($urandom & 32'hFFFF_E0FF);
    pc = ($urandom_range(0, 7) == 0) ? 32'd0 : ({$urandom} & 32'h0000_FFFC);
    if ($urandom_range(0, 15) == 0) pc = 32'd4;
    st = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_FF03) : $urandom;
    wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
    wd = $urandom;
    if (wa == 5'd12 && $urandom_range(0, 1) == 0) wd = wd & 32'h0000_FF03;
    drive(r, 6'($urandom), et, pc, 1'($urandom), st, $urandom & 32'h00C0_FF00,
          $urandom, ($urandom_range(0, 2) == 0), wa, wd);
  endtask

  // Monitor: one expected vector per clock, compared just after the edge.
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual_vec();
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL out_vec cycle %0d: got %h expected %h (we,code,epc,bd,eret,flush,pc,busy,int_o)",
                   cyc, a, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.int_i = 6'd0; bus.excepttype_i = 32'd0; bus.inst_addr_i = 32'd0;
    bus.in_delayslot_i = 1'b0; bus.cp0_status_i = 32'd0; bus.cp0_cause_i = 32'd0;
    bus.cp0_epc_i = 32'd0; bus.wb_cp0_we_i = 1'b0; bus.wb_cp0_addr_i = 5'd0;
    bus.wb_cp0_data_i = 32'd0;
    @(posedge clk);
    #2;

    // Reset with random inputs, then a syscall right after release.
    for (int i = 0; i < 3; i++)
      drive(1'b0, 6'($urandom), $urandom, $urandom, 1'($urandom), $urandom, $urandom,
            $urandom, 1'($urandom), 5'($urandom), $urandom);
    drive(1'b1, 6'd0, 32'h100, 32'h40, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);

    // Overflow in a delay slot; busy spans FLUSH plus the blank window.
    drive(1'b1, 6'd0, 32'h800, 32'h104, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);

    // Interrupt beats syscall; with EXL set the syscall wins.
    drive(1'b1, 6'd0, 32'h100, 32'h80, 1'b0, 32'h0000_FF01, 32'h0000_0400, 32'd0,
          1'b0, 5'd0, 32'd0);
    idle(4);
    drive(1'b1, 6'd0, 32'h100, 32'h80, 1'b0, 32'h0000_FF03, 32'h0000_0400, 32'd0,
          1'b0, 5'd0, 32'd0);
    idle(4);

    // eret picks up the forwarded EPC.
    drive(1'b1, 6'd0, 32'h1000, 32'h90, 1'b0, 32'd0, 32'd0, 32'h200, 1'b1, 5'd14,
          32'h300);
    idle(4);

    // Forwarded Status enables an interrupt that the register file has not seen yet.
    drive(1'b1, 6'd0, 32'h0, 32'h94, 1'b0, 32'd0, 32'h0000_0800, 32'd0, 1'b1, 5'd12,
          32'h0000_0801);
    idle(4);

    // Delay-slot PC 4 wraps EPC to 0; PC 0 is a bubble and never triggers.
    drive(1'b1, 6'd0, 32'h200, 32'h4, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);
    drive(1'b1, 6'd0, 32'h100, 32'h0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Syscall held: the repeat during the blank window is dropped, then accepted.
    for (int i = 0; i < 6; i++)
      drive(1'b1, 6'd0, 32'h100, 32'hA0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);

    // Reset asserted while flush_o is high clears the outputs at once.
    drive(1'b1, 6'd0, 32'h400, 32'hB0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.flush_o !== 1'b0 || bus.exc_we_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.new_pc_o !== 32'd0) begin
      n_err++;
      $display("FAIL midflush_reset: flush=%b we=%b busy=%b new_pc=%h required all 0",
               bus.flush_o, bus.exc_we_o, bus.busy_o, bus.new_pc_o);
    end
    drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 6'b000001, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 6'b000000, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 6'b000000, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    for (int i = 0; i < 400; i++) rand_cycle();
    idle(2);

    @(posedge clk);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
